// File: rtl/rv32i_decode_exec.sv
// Decode/execute slice of the RV32I pipeline: instruction decode, EX forwarding
// and ALU, all combinational, plus a sticky illegal-instruction flag.
module rv32i_decode_exec (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_raw,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [3:0]  alu_op,
  output logic [31:0] imm,
  output logic        illegal,
  input  logic [4:0]  ex_rs1_addr,
  input  logic [4:0]  ex_rs2_addr,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_val,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_val,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  input  logic [3:0]  ex_alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_NE   = 4'd12;
  localparam logic [3:0] OP_GE   = 4'd13;
  localparam logic [3:0] OP_GEU  = 4'd14;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic        unused_rs1_field;

  assign opcode = instr_raw[6:0];
  assign funct3 = instr_raw[14:12];
  assign funct7 = instr_raw[31:25];
  assign imm_i  = {{20{instr_raw[31]}}, instr_raw[31:20]};
  assign imm_s  = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
  assign imm_b  = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                   instr_raw[30:25], instr_raw[11:8], 1'b0};
  assign unused_rs1_field = ^instr_raw[19:15];

  logic        dec_legal;
  logic        dec_branch;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_alu_src;
  logic        dec_reg_write;
  logic [3:0]  dec_op;
  logic [31:0] dec_imm;

  always_comb begin
    dec_legal     = 1'b0;
    dec_branch    = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_op        = OP_NONE;
    dec_imm       = '0;
    case (opcode)
      7'b0110011: begin
        dec_reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec_op    = OP_SRA;
        end
      end
      7'b0010011: begin
        dec_legal     = 1'b1;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_imm       = imm_i;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = instr_raw[30] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      7'b0000011: begin
        dec_legal     = (funct3 == 3'b010);
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_op        = OP_ADD;
        dec_imm       = imm_i;
      end
      7'b0100011: begin
        dec_legal     = (funct3 == 3'b010);
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_op        = OP_ADD;
        dec_imm       = imm_s;
      end
      7'b1100011: begin
        dec_legal  = 1'b1;
        dec_branch = 1'b1;
        dec_imm    = imm_b;
        case (funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NE;
          3'b100:  dec_op = OP_SLT;
          3'b101:  dec_op = OP_GE;
          3'b110:  dec_op = OP_SLTU;
          3'b111:  dec_op = OP_GEU;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    // Anything not fully decoded collapses to a bubble.
    if (!dec_legal) begin
      dec_branch    = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_alu_src   = 1'b0;
      dec_reg_write = 1'b0;
      dec_op        = OP_NONE;
      dec_imm       = '0;
    end
  end

  assign branch    = dec_branch    & ~reset;
  assign mem_read  = dec_mem_read  & ~reset;
  assign mem_write = dec_mem_write & ~reset;
  assign alu_src   = dec_alu_src   & ~reset;
  assign reg_write = dec_reg_write & ~reset;
  assign alu_op    = reset ? OP_NONE : dec_op;
  assign imm       = dec_imm;

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (!dec_legal) begin
      illegal <= 1'b1;
    end
  end

  // MEM stage wins over WB; x0 always reads the ID/EX value.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] ex_val,
    input logic        m_we,
    input logic [4:0]  m_rd,
    input logic [31:0] m_val,
    input logic [4:0]  w_rd,
    input logic [31:0] w_val
  );
    if (src != 5'd0 && m_we && m_rd == src) begin
      return m_val;
    end else if (src != 5'd0 && w_rd == src) begin
      return w_val;
    end
    return ex_val;
  endfunction

  assign rs1 = fwd_sel(ex_rs1_addr, ex_rs1_val, mem_reg_write, mem_rd_addr,
                       mem_rd_val, wb_rd_addr, wb_rd_val);
  assign rs2 = fwd_sel(ex_rs2_addr, ex_rs2_val, mem_reg_write, mem_rd_addr,
                       mem_rd_val, wb_rd_addr, wb_rd_val);

  always_comb begin
    alu_result = '0;
    case (ex_alu_op)
      OP_ADD:  alu_result = alu_src1 + alu_src2;
      OP_SUB:  alu_result = alu_src1 - alu_src2;
      OP_SLL:  alu_result = alu_src1 << alu_src2[4:0];
      OP_SLT:  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      OP_SLTU: alu_result = {31'd0, alu_src1 < alu_src2};
      OP_XOR:  alu_result = alu_src1 ^ alu_src2;
      OP_SRL:  alu_result = alu_src1 >> alu_src2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
      OP_OR:   alu_result = alu_src1 | alu_src2;
      OP_AND:  alu_result = alu_src1 & alu_src2;
      OP_EQ:   alu_result = {31'd0, alu_src1 == alu_src2};
      OP_NE:   alu_result = {31'd0, alu_src1 != alu_src2};
      OP_GE:   alu_result = {31'd0, $signed(alu_src1) >= $signed(alu_src2)};
      OP_GEU:  alu_result = {31'd0, alu_src1 >= alu_src2};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed, table-driven bench for rv32i_decode_exec: decode, ALU and
// forwarding tables plus hand sequences for the sticky illegal flag and reset.
module tb_rv32i_decode_exec;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_raw;
  logic        branch, mem_read, mem_write, alu_src, reg_write;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic        illegal;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr;
  logic [31:0] ex_rs1_val, ex_rs2_val;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_val;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;
  logic [31:0] rs1, rs2;
  logic [3:0]  ex_alu_op;
  logic [31:0] alu_src1, alu_src2;
  logic [31:0] alu_result;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rv32i_decode_exec dut (
    .clock(clock), .reset(reset), .instr_raw(instr_raw),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .imm(imm),
    .illegal(illegal),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_rd_val(mem_rd_val),
    .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .rs1(rs1), .rs2(rs2),
    .ex_alu_op(ex_alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ctl = {branch, mem_read, mem_write, alu_src, reg_write}
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  ctl;
    logic [3:0]  op;
    logic [31:0] imm;
  } dec_vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } alu_vec_t;

  typedef struct packed {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        mwe;
    logic [4:0]  mrd;
    logic [4:0]  wrd;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } fwd_vec_t;

  localparam logic [31:0] EX1 = 32'h1111_1111;
  localparam logic [31:0] EX2 = 32'h2222_2222;
  localparam logic [31:0] VA  = 32'hAAAA_0001;
  localparam logic [31:0] VB  = 32'hBBBB_0002;

  dec_vec_t dv[17];
  alu_vec_t av[16];
  fwd_vec_t fv[6];

  initial begin
    dv[0]  = '{32'h00500093, 5'b00011, 4'd1,  32'h00000005}; // addi x1,x0,5
    dv[1]  = '{32'hFFF00093, 5'b00011, 4'd1,  32'hFFFFFFFF}; // addi x1,x0,-1
    dv[2]  = '{32'h0020A223, 5'b00110, 4'd1,  32'h00000004}; // sw
    dv[3]  = '{32'hFE208EE3, 5'b10000, 4'd11, 32'hFFFFFFFC}; // beq
    dv[4]  = '{32'h002081B3, 5'b00001, 4'd1,  32'h00000000}; // add
    dv[5]  = '{32'h402081B3, 5'b00001, 4'd2,  32'h00000000}; // sub
    dv[6]  = '{32'h4020D1B3, 5'b00001, 4'd8,  32'h00000000}; // sra
    dv[7]  = '{32'h00812083, 5'b01011, 4'd1,  32'h00000008}; // lw
    dv[8]  = '{32'h4030D093, 5'b00011, 4'd8,  32'h00000403}; // srai
    dv[9]  = '{32'hFE20EEE3, 5'b10000, 4'd5,  32'hFFFFFFFC}; // bltu
    dv[10] = '{32'hFE20DEE3, 5'b10000, 4'd13, 32'hFFFFFFFC}; // bge
    dv[11] = '{32'hFFF0F093, 5'b00011, 4'd10, 32'hFFFFFFFF}; // andi
    dv[12] = '{32'h00000000, 5'b00000, 4'd0,  32'h00000000}; // all zero
    dv[13] = '{32'hFE20AEE3, 5'b00000, 4'd0,  32'h00000000}; // branch funct3 010
    dv[14] = '{32'h4020C1B3, 5'b00000, 4'd0,  32'h00000000}; // xor with funct7 0100000
    dv[15] = '{32'h00810083, 5'b00000, 4'd0,  32'h00000000}; // lb unsupported
    dv[16] = '{32'h000000B7, 5'b00000, 4'd0,  32'h00000000}; // lui unsupported

    av[0]  = '{4'd2,  32'h00000003, 32'h00000005, 32'hFFFFFFFE};
    av[1]  = '{4'd8,  32'h80000000, 32'h00000004, 32'hF8000000};
    av[2]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    av[3]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    av[4]  = '{4'd14, 32'h00000005, 32'h00000005, 32'h00000001};
    av[5]  = '{4'd0,  32'h00000001, 32'h00000002, 32'h00000000};
    av[6]  = '{4'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    av[7]  = '{4'd3,  32'h00000001, 32'h00000021, 32'h00000002};
    av[8]  = '{4'd7,  32'h80000000, 32'h00000004, 32'h08000000};
    av[9]  = '{4'd6,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
    av[10] = '{4'd9,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
    av[11] = '{4'd10, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    av[12] = '{4'd11, 32'h00000007, 32'h00000007, 32'h00000001};
    av[13] = '{4'd12, 32'h00000007, 32'h00000007, 32'h00000000};
    av[14] = '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    av[15] = '{4'd15, 32'h00000001, 32'h00000001, 32'h00000000};

    fv[0] = '{5'd3, 5'd4, 1'b1, 5'd3, 5'd3, VA,  EX2};
    fv[1] = '{5'd3, 5'd4, 1'b0, 5'd3, 5'd3, VB,  EX2};
    fv[2] = '{5'd0, 5'd4, 1'b1, 5'd0, 5'd0, EX1, EX2};
    fv[3] = '{5'd4, 5'd4, 1'b1, 5'd4, 5'd4, VA,  VA};
    fv[4] = '{5'd1, 5'd5, 1'b1, 5'd6, 5'd5, EX1, VB};
    fv[5] = '{5'd7, 5'd0, 1'b0, 5'd0, 5'd7, VB,  EX2};

    reset = 1'b1;
    instr_raw = 32'h00500093;
    ex_rs1_addr = '0; ex_rs2_addr = '0;
    ex_rs1_val = EX1; ex_rs2_val = EX2;
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_rd_val = VA;
    wb_rd_addr = '0; wb_rd_val = VB;
    ex_alu_op = '0; alu_src1 = '0; alu_src2 = '0;

    // Reset: controls forced off, imm still decoded, flag cleared by the edge.
    @(negedge clock);
    #1;
    check("reset_reg_write", {31'd0, reg_write}, 32'd0);
    check("reset_alu_op", {28'd0, alu_op}, 32'd0);
    check("reset_imm", imm, 32'h00000005);
    check("reset_illegal", {31'd0, illegal}, 32'd0);

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      instr_raw = dv[i].instr;
      #1;
      check($sformatf("dec%0d_ctl", i),
            {27'd0, branch, mem_read, mem_write, alu_src, reg_write}, {27'd0, dv[i].ctl});
      check($sformatf("dec%0d_op", i), {28'd0, alu_op}, {28'd0, dv[i].op});
      check($sformatf("dec%0d_imm", i), imm, dv[i].imm);
      @(negedge clock);
    end

    for (int i = 0; i < 16; i++) begin
      ex_alu_op = av[i].op;
      alu_src1 = av[i].a;
      alu_src2 = av[i].b;
      #1;
      check($sformatf("alu%0d_op%0d", i, av[i].op), alu_result, av[i].res);
    end

    for (int i = 0; i < 6; i++) begin
      ex_rs1_addr = fv[i].s1;
      ex_rs2_addr = fv[i].s2;
      mem_reg_write = fv[i].mwe;
      mem_rd_addr = fv[i].mrd;
      wb_rd_addr = fv[i].wrd;
      #1;
      check($sformatf("fwd%0d_rs1", i), rs1, fv[i].exp1);
      check($sformatf("fwd%0d_rs2", i), rs2, fv[i].exp2);
    end

    // Sticky illegal flag sequence.
    @(negedge clock);
    reset = 1'b1;
    instr_raw = 32'h00500093;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ill_clear_after_reset", {31'd0, illegal}, 32'd0);
    instr_raw = 32'h00000000;
    #1;
    check("ill_before_edge", {31'd0, illegal}, 32'd0);
    @(negedge clock);
    check("ill_set", {31'd0, illegal}, 32'd1);
    instr_raw = 32'h002081B3;
    @(negedge clock);
    check("ill_sticky1", {31'd0, illegal}, 32'd1);
    instr_raw = 32'h00500093;
    @(negedge clock);
    check("ill_sticky2", {31'd0, illegal}, 32'd1);
    reset = 1'b1;
    instr_raw = 32'h00000000;
    @(negedge clock);
    check("ill_reset_wins", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    instr_raw = 32'h00500093;
    @(negedge clock);
    check("ill_stays_clear", {31'd0, illegal}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_exec.md
# rv32i_decode_exec

Combined decode/execute slice of the 5-stage RV32I pipeline core. It decodes a raw instruction into control bits and a sign-extended immediate. It resolves EX-stage operand forwarding from the MEM and WB pipeline registers, and computes the ALU result, which also serves as the branch-taken flag. Decode, forwarding and ALU are purely combinational; the only state is a sticky illegal-instruction flag.

## Interface
Parameters: none.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_raw  in  32  ID-stage instruction
- branch, mem_read, mem_write, alu_src, reg_write  out  1 each  decoded controls
- alu_op  out  4  decoded ALU operation
- imm  out  32  sign-extended immediate
- illegal  out  1  sticky: an unsupported instruction was decoded
- ex_rs1_addr, ex_rs2_addr  in  5  EX-stage source register numbers
- ex_rs1_val, ex_rs2_val  in  32  register-file values latched in ID/EX
- mem_reg_write  in  1; mem_rd_addr  in  5; mem_rd_val  in  32  EX/MEM destination
- wb_rd_addr  in  5; wb_rd_val  in  32  MEM/WB destination (addr 0 = no write)
- rs1, rs2  out  32  forwarded operands
- ex_alu_op  in  4; alu_src1, alu_src2  in  32  ALU inputs
- alu_result  out  32

One clock; reset is synchronous and active-high.

## Operation
- alu_op encoding:
  - 0 NONE→0, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND.
  - 11 EQ, 12 NE, 13 GE (signed), 14 GEU, 15 reserved→0.
  - Comparisons return 32'd1 or 32'd0. Shifts use alu_src2[4:0]. All arithmetic is 32-bit modulo.
- Decode by opcode:
  - OP (0110011): funct7 must be 0000000, or 0100000 for SUB/SRA; alu_src=0, reg_write=1, imm=0.
  - OP-IMM (0010011): I-immediate, alu_src=1, reg_write=1. SRAI is selected when instr[30]=1; SLLI/SRLI/SRAI pass the raw I-immediate.
  - LOAD (0000011): funct3=010 only. mem_read=1, reg_write=1, alu_src=1, ADD, I-immediate.
  - STORE (0100011): funct3=010 only. mem_write=1, alu_src=1, ADD, S-immediate.
  - BRANCH (1100011): branch=1, alu_src=0, B-immediate (bit0=0). Opcode mapping is BEQ→EQ, BNE→NE, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU; funct3 010/011 are illegal.
  - Any other opcode or funct combination is illegal: all controls 0, alu_op=NONE, imm=0.
- reset high forces all decoded control outputs to 0 and alu_op to NONE; imm is still computed.
- Forwarding, evaluated independently for rs1 and rs2:
  - MEM has priority: if mem_reg_write and mem_rd_addr==src and src!=0, the operand is mem_rd_val.
  - Otherwise, if wb_rd_addr==src and src!=0, the operand is wb_rd_val.
  - Otherwise the operand is ex_rsN_val.
  - Register x0 is never forwarded.
- Load-use hazards are not detected. The MEM path forwards the load address; software inserts two NOPs after a load whose result is used.

## Timing
- All decode, forward and ALU outputs are combinational, with zero latency.
- illegal: cleared to 0 on a clock edge with reset=1. Otherwise it is set on any edge where the current instr_raw decodes as illegal, and it stays set until reset.
- When reset and an illegal decode occur on the same edge, reset wins and illegal is 0.

## Test plan
- Decode: 0x00500093 (addi x1,x0,5) → reg_write=1, alu_src=1, alu_op=ADD, imm=5. 0xFFF00093 → imm=0xFFFFFFFF.
- Decode: 0x0020A223 (sw x2,4(x1)) → mem_write=1, reg_write=0, imm=4. 0xFE208EE3 (beq x1,x2,-4) → branch=1, alu_op=EQ, imm=0xFFFFFFFC.
- ALU: SUB 3−5 → 0xFFFFFFFE; SRA 0x80000000 by 4 → 0xF8000000; SLT(−1,1)=1 while SLTU(−1,1)=0; GEU(5,5)=1; NONE → 0.
- Forward: src=3, mem_reg_write=1, mem_rd=3 (val A), wb_rd=3 (val B) → A. With mem_reg_write=0 → B. With src=0 → ex_rs1_val.
- Illegal: 0x00000000 → controls all 0, and illegal=1 after the next edge. It stays set with subsequent legal instructions and clears after a reset cycle.
- Reset: reset=1 with instr 0x00500093 → reg_write=0, alu_op=0, illegal=0 after the edge.
